// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared types and constants for the seven-segment display driver.
//   SEG7_NUM_DIGITS : number of digits on the board display
//   seg7_t          : active-low segment vector {g,f,e,d,c,b,a}
//   seg7_state_e    : per-slot scan phase (BLANK, DRIVE)
//   SEG7_OFF        : all segments dark
//   ANODES_OFF      : all anodes disabled
//   hex_to_seg7()   : nibble -> active-low segment pattern
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int SEG7_NUM_DIGITS = 8;

    typedef logic [6:0] seg7_t;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } seg7_state_e;

    localparam seg7_t      SEG7_OFF   = 7'h7F;
    localparam logic [7:0] ANODES_OFF = 8'hFF;

    function automatic seg7_t hex_to_seg7(input logic [3:0] nibble);
        seg7_t seg;
        case (nibble)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = SEG7_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_display_driver_hex_decoder.sv
// -----------------------------------------------------------------------------
// seg7_hex_decoder
// Purely combinational hex nibble to active-low seven-segment decoder.
//   i_nibble : 4-bit value to display
//   o_seg    : active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg7_t      o_seg
);

    assign o_seg = hex_to_seg7(i_nibble);

endmodule

// File: rtl/seg7_display_driver.sv
// -----------------------------------------------------------------------------
// seg7_display_driver
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Each digit slot starts with an all-off blanking interval, then drives the
// selected digit. Display data is double-buffered: a loaded word is held as
// pending and copied into the shadow register only at the frame boundary.
//
// Ports:
//   clk          : system clock
//   arst_n       : synchronous active-low reset
//   i_data       : display word, nibble i shown on digit i
//   i_dots       : decimal point request per digit (1 = lit)
//   i_digit_en   : live per-digit enable (0 = dark, timing unchanged)
//   i_load       : 1-cycle strobe capturing i_data/i_dots as pending word
//   o_anodes     : anode enables, active-low
//   o_segments   : segments {g,f,e,d,c,b,a}, active-low
//   o_dp         : decimal point, active-low
//   o_frame_done : 1-cycle pulse after the last cycle of each full scan
//
// Build option:
//   SEG7_LEADING_ZERO_BLANK_EN : when defined, leading zero digits of the
//   shadow word are suppressed (digit 0 and digits with a lit dot excepted).
// -----------------------------------------------------------------------------
module seg7_display_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS           = SEG7_NUM_DIGITS,
    parameter int DIGIT_REFRESH_CYCLES = 100000,
    parameter int BLANK_CYCLES         = 1000
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic [4*NUM_DIGITS-1:0] i_data,
    input  logic [NUM_DIGITS-1:0]   i_dots,
    input  logic [NUM_DIGITS-1:0]   i_digit_en,
    input  logic                    i_load,
    output logic [NUM_DIGITS-1:0]   o_anodes,
    output seg7_t                   o_segments,
    output logic                    o_dp,
    output logic                    o_frame_done
);

    localparam int CNT_W = $clog2(DIGIT_REFRESH_CYCLES);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIGIT_REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    seg7_state_e             state_q, state_d;
    logic [4*NUM_DIGITS-1:0] shadow_data_q, shadow_data_d;
    logic [NUM_DIGITS-1:0]   shadow_dots_q, shadow_dots_d;
    logic [4*NUM_DIGITS-1:0] pending_data_q, pending_data_d;
    logic [NUM_DIGITS-1:0]   pending_dots_q, pending_dots_d;
    logic                    pending_q, pending_d;
    logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;
    seg7_t                   segments_q, segments_d;
    logic                    dp_q, dp_d;
    logic                    frame_done_q, frame_done_d;

    logic                    cnt_wrap_s;
    logic                    boundary_s;
    logic [3:0]              nibble_s;
    seg7_t                   dec_seg_s;
    logic [NUM_DIGITS-1:0]   suppress_s;
    logic                    digit_on_s;

    // Slot-end and frame-end detection.
    always_comb begin
        cnt_wrap_s = (cnt_q == CNT_LAST);
        boundary_s = cnt_wrap_s && (idx_q == IDX_LAST);
    end

    // Slot counter, digit index and BLANK/DRIVE next-state logic.
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        state_d = state_q;
        if (cnt_wrap_s) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end
        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = DRIVE;
                end else begin
                    state_d = BLANK;
                end
            end
            DRIVE: begin
                if (cnt_wrap_s) begin
                    state_d = BLANK;
                end else begin
                    state_d = DRIVE;
                end
            end
            default: state_d = BLANK;
        endcase
    end

    // Pending/shadow double buffer; a load in the boundary cycle bypasses pending.
    always_comb begin
        shadow_data_d  = shadow_data_q;
        shadow_dots_d  = shadow_dots_q;
        pending_data_d = pending_data_q;
        pending_dots_d = pending_dots_q;
        pending_d      = pending_q;
        if (boundary_s) begin
            if (i_load) begin
                shadow_data_d = i_data;
                shadow_dots_d = i_dots;
                pending_d     = 1'b0;
            end else if (pending_q) begin
                shadow_data_d = pending_data_q;
                shadow_dots_d = pending_dots_q;
                pending_d     = 1'b0;
            end else begin
                pending_d     = 1'b0;
            end
        end else if (i_load) begin
            pending_data_d = i_data;
            pending_dots_d = i_dots;
            pending_d      = 1'b1;
        end else begin
            pending_d      = pending_q;
        end
    end

    // Leading-zero suppression mask computed from the shadow word.
    always_comb begin
        logic zero_run;
        suppress_s = '0;
        zero_run   = 1'b1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run & (shadow_data_q[4*i +: 4] == 4'h0);
            suppress_s[i] = zero_run & ~shadow_dots_q[i] & (i != 0);
        end
`else
        suppress_s = '0;
        zero_run   = 1'b0;
`endif
    end

    assign nibble_s   = shadow_data_q[{idx_q, 2'b00} +: 4];
    assign digit_on_s = i_digit_en[idx_q] & ~suppress_s[idx_q];

    seg7_hex_decoder u_hex_decoder (
        .i_nibble (nibble_s),
        .o_seg    (dec_seg_s)
    );

    // Next values of the registered pin outputs.
    always_comb begin
        anodes_d     = ANODES_OFF;
        segments_d   = SEG7_OFF;
        dp_d         = 1'b1;
        frame_done_d = boundary_s;
        if (state_q == DRIVE) begin
            if (digit_on_s) begin
                anodes_d = ~(NUM_DIGITS'(1) << idx_q);
            end else begin
                anodes_d = ANODES_OFF;
            end
            segments_d = dec_seg_s;
            dp_d       = ~shadow_dots_q[idx_q];
        end else begin
            anodes_d   = ANODES_OFF;
            segments_d = SEG7_OFF;
            dp_d       = 1'b1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            cnt_q          <= '0;
            idx_q          <= '0;
            state_q        <= BLANK;
            shadow_data_q  <= '0;
            shadow_dots_q  <= '0;
            pending_data_q <= '0;
            pending_dots_q <= '0;
            pending_q      <= 1'b0;
            anodes_q       <= ANODES_OFF;
            segments_q     <= SEG7_OFF;
            dp_q           <= 1'b1;
            frame_done_q   <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            state_q        <= state_d;
            shadow_data_q  <= shadow_data_d;
            shadow_dots_q  <= shadow_dots_d;
            pending_data_q <= pending_data_d;
            pending_dots_q <= pending_dots_d;
            pending_q      <= pending_d;
            anodes_q       <= anodes_d;
            segments_q     <= segments_d;
            dp_q           <= dp_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign o_anodes     = anodes_q;
    assign o_segments   = segments_q;
    assign o_dp         = dp_q;
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_display_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_display_driver
// Scoreboard bench: the stimulus process predicts the pin values produced by
// each clock edge from a frame-level model (cycle time since reset, digit and
// slot position by division) and queues them; a monitor pops and compares one
// entry per edge.
// -----------------------------------------------------------------------------
module tb_seg7_display_driver;

    localparam int REFRESH = 8;
    localparam int BLANK   = 2;
    localparam int FRAME   = 8 * REFRESH;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [31:0] i_data;
    logic [7:0]  i_dots;
    logic [7:0]  i_digit_en;
    logic        i_load;
    logic [7:0]  o_anodes;
    logic [6:0]  o_segments;
    logic        o_dp;
    logic        o_frame_done;

    seg7_display_driver #(
        .NUM_DIGITS           (8),
        .DIGIT_REFRESH_CYCLES (REFRESH),
        .BLANK_CYCLES         (BLANK)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .i_data       (i_data),
        .i_dots       (i_dots),
        .i_digit_en   (i_digit_en),
        .i_load       (i_load),
        .o_anodes     (o_anodes),
        .o_segments   (o_segments),
        .o_dp         (o_dp),
        .o_frame_done (o_frame_done)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int          m_t;
    logic [31:0] m_shadow;
    logic [7:0]  m_sdots;
    logic [31:0] m_pend;
    logic [7:0]  m_pdots;
    bit          m_pend_v;
    logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic bit digit_suppressed(int d);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        int top_nz;
        top_nz = 0;
        for (int k = 0; k < 8; k++) begin
            if (((m_shadow >> (4 * k)) & 32'hF) != 32'h0) top_nz = k;
        end
        return (d > top_nz) && (m_sdots[d] == 1'b0);
`else
        return (d < 0);
`endif
    endfunction

    // Predict the pin values after the coming edge, then advance the model.
    task automatic tick();
        exp_t e;
        int   pos, dig;
        logic [3:0] nib;
        if (!arst_n) begin
            e = '{8'hFF, 7'h7F, 1'b1, 1'b0};
            m_t = 0; m_shadow = '0; m_sdots = '0; m_pend = '0; m_pdots = '0; m_pend_v = 0;
        end else begin
            pos = m_t % REFRESH;
            dig = (m_t / REFRESH) % 8;
            e = '{8'hFF, 7'h7F, 1'b1, 1'b0};
            if (pos >= BLANK) begin
                nib   = m_shadow[4*dig +: 4];
                e.seg = hex_tab[nib];
                e.dp  = ~m_sdots[dig];
                if (i_digit_en[dig] && !digit_suppressed(dig)) e.an = ~(8'h01 << dig);
            end
            e.fd = ((m_t % FRAME) == FRAME - 1);
            if (e.fd) begin
                if (i_load) begin
                    m_shadow = i_data; m_sdots = i_dots; m_pend_v = 0;
                end else if (m_pend_v) begin
                    m_shadow = m_pend; m_sdots = m_pdots; m_pend_v = 0;
                end
            end else if (i_load) begin
                m_pend = i_data; m_pdots = i_dots; m_pend_v = 1;
            end
            m_t++;
        end
        exp_q.push_back(e);
        @(negedge clk);
        i_load = 1'b0;
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic run_to(int frame_pos);
        while ((m_t % FRAME) != frame_pos) tick();
    endtask

    task automatic load(logic [31:0] d, logic [7:0] dots);
        i_data = d; i_dots = dots; i_load = 1'b1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: one scoreboard entry per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("anodes",     32'(o_anodes),     32'(e.an));
                chk("segments",   32'(o_segments),   32'(e.seg));
                chk("dp",         32'(o_dp),         32'(e.dp));
                chk("frame_done", 32'(o_frame_done), 32'(e.fd));
            end
        end
    end

    // Stimulus
    initial begin
        arst_n = 1'b0; i_data = '0; i_dots = '0; i_digit_en = 8'hFF; i_load = 1'b0;
        m_t = 0; m_shadow = '0; m_sdots = '0; m_pend = '0; m_pdots = '0; m_pend_v = 0;
        run(3);
        arst_n = 1'b1;

        // First word appears only after the first boundary
        load(32'h76543210, 8'h00);
        run(2 * FRAME);

        // Mid-scan load during digit 3
        run_to(3 * REFRESH + 4);
        load(32'hDEADBEEF, 8'h00);
        run(2 * FRAME);

        // Two loads in one frame: last wins
        run_to(5);
        load(32'h11111111, 8'h00);
        run(20);
        load(32'h22222222, 8'h00);
        run(2 * FRAME);

        // Load exactly in the boundary cycle
        run_to(FRAME - 1);
        load(32'hAAAAAAAA, 8'h00);
        run(2 * REFRESH);

        // Partial enables and a single dot
        i_digit_en = 8'h0F;
        load(32'h89ABCDEF, 8'h01);
        run(3 * FRAME);
        i_digit_en = 8'hFF;

        // Randomized traffic
        for (int k = 0; k < 1200; k++) begin
            if ($urandom_range(0, 19) == 0) load($urandom, 8'($urandom));
            if ($urandom_range(0, 49) == 0) i_digit_en = 8'($urandom);
            tick();
        end
        i_digit_en = 8'hFF;

        // Reset during digit 5 DRIVE, coincident with a load
        load(32'h12345678, 8'h00);
        run(FRAME);
        run_to(5 * REFRESH + 4);
        arst_n = 1'b0;
        load(32'hFFFFFFFF, 8'hFF);
        tick();
        arst_n = 1'b1;
        run(FRAME);

        // Leading zeros (suppressed only when the option is built in)
        load(32'h00000A00, 8'h00);
        run(2 * FRAME);
        load(32'h00000000, 8'h08);
        run(2 * FRAME);

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
